tcm_ctrl: RTL

Single-port TCM access controller that drives the masked-write SRAM macro port (din/addr/we/wem/dout) from the core's load/store request channel. It accepts one valid/ready command per cycle, generates word index, byte-lane write mask and lane-replicated write data, and returns a response per command. Read data from the SRAM arrives one cycle after the address and is captured into a hold register under response backpressure. Sits between the LSU/IFU request mux and the ITCM/DTCM RAM instance.

---
 rtl/tcm_if.sv | 27 ++
 rtl/tcm_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tcm_if.sv
// Load/store request and response channel between the LSU/IFU mux and tcm_ctrl.
// Parameterised by byte-address width (AW) and data width (DW).
interface tcm_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [1:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_size, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_size, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/tcm_ctrl.sv
// Single-port TCM access controller driving a masked-write SRAM macro.
// Optional misaligned-access checking is enabled by defining TCM_MISALIGN_CHK_EN.
module tcm_ctrl #(
    parameter int unsigned DP  = 512,
    parameter int unsigned RAW = $clog2(DP),
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned MW  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    tcm_if.slave           bus,
    output logic [RAW-1:0] ram_addr,
    output logic [DW-1:0]  ram_din,
    output logic           ram_we,
    output logic [MW-1:0]  ram_wem,
    input  logic [DW-1:0]  ram_dout
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LIVE  = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           rd_q;
    logic           err_q;
    logic [DW-1:0]  hold_q;
    logic [RAW-1:0] addr_q;

    logic           accept;
    logic           misalign;
    logic [RAW-1:0] idx;
    logic [MW-1:0]  mask;
    logic [DW-1:0]  live;
    logic [DW-1:0]  rdata;

    assign idx    = bus.cmd_addr[RAW+1:2];
    assign accept = bus.cmd_valid & bus.cmd_ready;

    // Address bits above the RAM depth are intentionally ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.cmd_addr[AW-1:RAW+2];

`ifdef TCM_MISALIGN_CHK_EN
    assign misalign = ((bus.cmd_size == 2'd1) & bus.cmd_addr[0]) |
                      (bus.cmd_size[1] & (|bus.cmd_addr[1:0]));
`else
    assign misalign = 1'b0;
`endif

    // Byte-lane mask and lane-replicated write data.
    always_comb begin
        mask    = '1;
        ram_din = bus.cmd_wdata;
        unique case (bus.cmd_size)
            2'd0: begin
                mask    = MW'(1) << bus.cmd_addr[1:0];
                ram_din = {4{bus.cmd_wdata[7:0]}};
            end
            2'd1: begin
                mask    = MW'(3) << {bus.cmd_addr[1], 1'b0};
                ram_din = {2{bus.cmd_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign ram_we   = accept & ~bus.cmd_read & ~misalign;
    assign ram_wem  = ram_we ? mask : '0;
    // Idle cycles re-present the last read index so ram_dout holds steady.
    assign ram_addr = accept ? idx : addr_q;

    assign bus.cmd_ready = ~bus.rsp_valid | bus.rsp_ready;
    assign bus.rsp_valid = (state_q != EMPTY);
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q  <= bus.cmd_read;
                err_q <= misalign;
            end
            if (accept && bus.cmd_read && !misalign) begin
                addr_q <= idx;
            end
            if (state_q == LIVE && !bus.rsp_ready) begin
                hold_q <= live;
            end
        end
    end

    // Response FSM: next state and response data selection.
    always_comb begin
        state_d = state_q;
        live    = '0;
        rdata   = '0;
        if (rd_q && !err_q) begin
            live = ram_dout;
        end
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = LIVE;
                end
            end
            LIVE, HELD: begin
                rdata = (state_q == LIVE) ? live : hold_q;
                if (bus.rsp_ready) begin
                    state_d = accept ? LIVE : EMPTY;
                end else begin
                    state_d = HELD;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

endmodule
